// File: rtl/accum_out_ctrl.sv
// rtl/accum_out_ctrl.sv - accumulator-to-output-memory row transfer with ReLU, rounding shift and saturation
//
// Ports:
//   clk, rstn                clock, asynchronous active-low reset
//   start                    one-cycle pulse launching a transfer (ignored unless idle)
//   num_row                  rows to move, sampled on start
//   accum_base_addr          first accumulator row, sampled on start
//   out_base_addr            first output address, sampled on start
//   relu_en, shift           activation / requantisation config, sampled on start
//   busy, done               status: busy while reading/draining, done pulses at the end
//   accum_rd_en/addr/data    per-column accumulator read port (data one cycle after enable)
//   out_wr_en/addr/data      per-bank output memory write port
module accum_out_ctrl #(
  parameter int SYS_COL          = 4,
  parameter int DATA_WIDTH       = 16,
  parameter int ACCUM_SIZE       = 1024,
  parameter int ADDR_WIDTH       = 8,
  parameter int ACCUM_ADDR_WIDTH = $clog2(ACCUM_SIZE / SYS_COL)
) (
  input  logic                                       clk,
  input  logic                                       rstn,
  input  logic                                       start,
  input  logic [DATA_WIDTH-1:0]                      num_row,
  input  logic [ACCUM_ADDR_WIDTH-1:0]                accum_base_addr,
  input  logic [ADDR_WIDTH-1:0]                      out_base_addr,
  input  logic                                       relu_en,
  input  logic [4:0]                                 shift,
  output logic                                       busy,
  output logic                                       done,
  output logic [SYS_COL-1:0]                         accum_rd_en,
  output logic [SYS_COL-1:0][ACCUM_ADDR_WIDTH-1:0]   accum_rd_addr,
  input  logic [SYS_COL-1:0][2*DATA_WIDTH-1:0]       accum_rd_data,
  output logic [SYS_COL-1:0]                         out_wr_en,
  output logic [SYS_COL-1:0][ADDR_WIDTH-1:0]         out_wr_addr,
  output logic [SYS_COL-1:0][DATA_WIDTH-1:0]         out_wr_data
);

  localparam int ACCUM_ROW = ACCUM_SIZE / SYS_COL;
  localparam int AW        = 2 * DATA_WIDTH;

  localparam logic signed [AW:0] SAT_MAX = (AW + 1)'(2 ** (DATA_WIDTH - 1) - 1);
  localparam logic signed [AW:0] SAT_MIN = -SAT_MAX - 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   num_q;
  logic [ADDR_WIDTH-1:0]   out_base_q;
  logic                    relu_q;
  logic [4:0]              shift_q;
  logic [DATA_WIDTH-1:0]   r;
  logic [ADDR_WIDTH-1:0]   w;
  // High in the cycle the accumulator presents data for a read issued the cycle before.
  logic                    rd_valid;

  function automatic logic [ACCUM_ADDR_WIDTH-1:0] next_row(input logic [ACCUM_ADDR_WIDTH-1:0] row);
    if (row >= ACCUM_ADDR_WIDTH'(ACCUM_ROW - 1)) return '0;
    return row + 1'b1;
  endfunction

  // ReLU, round-half-up arithmetic shift, then clamp to the output range.
  // Working width is one bit wider than the accumulator so the rounding add never wraps.
  function automatic logic [DATA_WIDTH-1:0] requant(input logic signed [AW-1:0] raw,
                                                     input logic              relu,
                                                     input logic [4:0]        sh);
    logic signed [AW:0] v;
    logic signed [AW:0] rnd;
    logic [5:0]         s;
    v = $signed({raw[AW-1], raw});
    if (relu && raw[AW-1]) v = '0;
    s = {1'b0, sh};
    if (s > 6'(AW - 1)) s = 6'(AW - 1);
    if (s != 6'd0) begin
      rnd = (AW + 1)'(1) << (s - 6'd1);
      v   = (v + rnd) >>> s;
    end
    if (v > SAT_MAX) v = SAT_MAX;
    else if (v < SAT_MIN) v = SAT_MIN;
    return v[DATA_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      num_q         <= '0;
      out_base_q    <= '0;
      relu_q        <= 1'b0;
      shift_q       <= '0;
      r             <= '0;
      w             <= '0;
      rd_valid      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      accum_rd_en   <= '0;
      accum_rd_addr <= '0;
      out_wr_en     <= '0;
      out_wr_addr   <= '0;
      out_wr_data   <= '0;
    end else begin
      done     <= 1'b0;
      rd_valid <= accum_rd_en[0];

      // Output stage: process the row the accumulator is presenting this cycle.
      out_wr_en <= {SYS_COL{rd_valid}};
      if (rd_valid) begin
        for (int c = 0; c < SYS_COL; c++) begin
          out_wr_data[c] <= requant(accum_rd_data[c], relu_q, shift_q);
        end
        out_wr_addr <= {SYS_COL{out_base_q + w}};
        w           <= w + 1'b1;
      end else begin
        out_wr_data <= '0;
        out_wr_addr <= '0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            num_q      <= num_row;
            out_base_q <= out_base_addr;
            relu_q     <= relu_en;
            shift_q    <= shift;
            r          <= '0;
            w          <= '0;
            if (num_row == '0) begin
              state <= FIN;
            end else begin
              state         <= READ;
              busy          <= 1'b1;
              accum_rd_en   <= '1;
              accum_rd_addr <= {SYS_COL{accum_base_addr}};
            end
          end
        end
        READ: begin
          // accum_rd_addr currently holds row r; stop after the last one is issued.
          if (r == num_q - 1'b1) begin
            accum_rd_en   <= '0;
            accum_rd_addr <= '0;
            state         <= DRAIN;
          end else begin
            r             <= r + 1'b1;
            accum_rd_addr <= {SYS_COL{next_row(accum_rd_addr[0])}};
          end
        end
        DRAIN: begin
          // The final row's data is on the bus; its write is registered at this edge.
          if (rd_valid) begin
            state <= FIN;
            busy  <= 1'b0;
          end
        end
        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_out_ctrl.sv
// tb/tb_accum_out_ctrl.sv - scoreboard testbench for accum_out_ctrl
module tb_accum_out_ctrl;
  localparam int SC = 4, DW = 16, AS = 1024, AW = 8, RW = 8, ROWS = 256;

  logic clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic [DW-1:0] num_row = '0;
  logic [RW-1:0] accum_base_addr = '0;
  logic [AW-1:0] out_base_addr = '0;
  logic relu_en = 1'b0;
  logic [4:0] shift = '0;
  logic busy, done;
  logic [SC-1:0] accum_rd_en;
  logic [SC-1:0][RW-1:0] accum_rd_addr;
  logic [SC-1:0][2*DW-1:0] accum_rd_data;
  logic [SC-1:0] out_wr_en;
  logic [SC-1:0][AW-1:0] out_wr_addr;
  logic [SC-1:0][DW-1:0] out_wr_data;

  accum_out_ctrl #(.SYS_COL(SC), .DATA_WIDTH(DW), .ACCUM_SIZE(AS), .ADDR_WIDTH(AW),
                   .ACCUM_ADDR_WIDTH(RW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .num_row(num_row),
    .accum_base_addr(accum_base_addr), .out_base_addr(out_base_addr),
    .relu_en(relu_en), .shift(shift), .busy(busy), .done(done),
    .accum_rd_en(accum_rd_en), .accum_rd_addr(accum_rd_addr), .accum_rd_data(accum_rd_data),
    .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data));

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]         addr;
    logic [SC-1:0][DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  rd_q[$];
  logic signed [31:0] mem [ROWS][SC];

  int tests = 0, fails = 0;
  int cyc = 0;
  int done_cnt = 0, done_cyc = 0, done_base = 0;
  int first_wr = -1, last_wr = -1, s_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Accumulator memory: registered read, data valid the cycle after the enable.
  always @(posedge clk) begin
    if (accum_rd_en[0]) begin
      for (int c = 0; c < SC; c++) accum_rd_data[c] <= mem[accum_rd_addr[c]][c];
    end
  end

  task automatic check_eq(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: relu, floor((v + 2^(s-1)) / 2^s), clamp to signed DW range.
  function automatic logic [DW-1:0] ref_q(input longint v, input bit relu, input int sh);
    longint x, den, q;
    int s;
    x = v;
    if (relu && x < 0) x = 0;
    s = (sh > 2*DW-1) ? 2*DW-1 : sh;
    if (s > 0) begin
      den = longint'(1) << s;
      x = x + den / 2;
      q = x / den;
      if ((x % den != 0) && (x < 0)) q = q - 1;
      x = q;
    end
    if (x > 32767) x = 32767;
    if (x < -32768) x = -32768;
    return DW'(x);
  endfunction

  // Monitor: compare every read request and every write against the scoreboard.
  always @(negedge clk) begin
    if (rstn) begin
      if (accum_rd_en != '0) begin
        check_eq("rd_en_all_cols", accum_rd_en, {SC{1'b1}});
        check_eq("read_expected", rd_q.size() > 0, 1);
        if (rd_q.size() > 0) begin
          int row;
          row = rd_q.pop_front();
          for (int c = 0; c < SC; c++) check_eq("rd_addr", accum_rd_addr[c], row);
        end
      end
      if (out_wr_en != '0) begin
        check_eq("wr_en_all_banks", out_wr_en, {SC{1'b1}});
        check_eq("write_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          wr_t e;
          e = exp_q.pop_front();
          for (int c = 0; c < SC; c++) begin
            check_eq("wr_addr", out_wr_addr[c], e.addr);
            check_eq("wr_data", $signed(out_wr_data[c]), $signed(e.data[c]));
          end
        end
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic issue(input int n, input int ab, input int ob, input bit relu, input int sh);
    wr_t e;
    for (int i = 0; i < n; i++) begin
      int row;
      row = (ab + i) % ROWS;
      rd_q.push_back(row);
      e.addr = AW'((ob + i) % 256);
      for (int c = 0; c < SC; c++) e.data[c] = ref_q(mem[row][c], relu, sh);
      exp_q.push_back(e);
    end
    @(negedge clk);
    num_row = DW'(n);
    accum_base_addr = RW'(ab);
    out_base_addr = AW'(ob);
    relu_en = relu;
    shift = 5'(sh);
    start = 1'b1;
    s_cyc = cyc;
    done_base = done_cnt;
    first_wr = -1;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", busy, n > 0);
    // Config changes mid-transfer must not matter.
    num_row = DW'($urandom);
    accum_base_addr = RW'($urandom);
    out_base_addr = AW'($urandom);
    relu_en = 1'($urandom);
    shift = 5'($urandom);
  endtask

  task automatic wait_done(input int n);
    int k;
    k = 0;
    while (done_cnt == done_base && k < 400) begin
      @(negedge clk);
      k++;
    end
    check_eq("done_seen", done_cnt - done_base, 1);
    if (done_cnt != done_base) begin
      if (n == 0) begin
        check_eq("done_latency_zero_rows", done_cyc - s_cyc, 2);
      end else begin
        check_eq("first_write_latency", first_wr - s_cyc, 3);
        check_eq("last_write_cycle", last_wr - s_cyc, 2 + n);
        check_eq("done_after_last_write", done_cyc - last_wr, 1);
      end
      check_eq("busy_at_done", busy, 0);
    end
    repeat (6) @(negedge clk);
    check_eq("single_done", done_cnt - done_base, 1);
    check_eq("writes_outstanding", exp_q.size(), 0);
    check_eq("reads_outstanding", rd_q.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_rd_en"}, accum_rd_en, 0);
    check_eq({tag, "_rd_addr"}, accum_rd_addr, 0);
    check_eq({tag, "_wr_en"}, out_wr_en, 0);
    check_eq({tag, "_wr_addr"}, out_wr_addr, 0);
    check_eq({tag, "_wr_data"}, out_wr_data, 0);
  endtask

  function automatic logic signed [31:0] rand_val();
    case ($urandom_range(0, 3))
      0: return 32'($signed(32'($urandom_range(0, 600))) - 300);
      1: return 32'($signed(32'($urandom_range(0, 200000))) - 100000);
      2: return $signed(32'($urandom));
      default: return ($urandom_range(0, 1) == 1) ? 32'sd32767 : -32'sd32768;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    for (int rr = 0; rr < ROWS; rr++)
      for (int c = 0; c < SC; c++) mem[rr][c] = rand_val();

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Basic transfer
    for (int rr = 0; rr < 4; rr++)
      for (int c = 0; c < SC; c++) mem[rr][c] = 100 * rr + c;
    issue(4, 0, 0, 1'b0, 0);
    wait_done(4);

    // ReLU and rounding
    mem[10][0] = -5; mem[10][1] = 7; mem[10][2] = 6; mem[10][3] = -6;
    issue(1, 10, 5, 1'b1, 2);
    wait_done(1);
    issue(1, 10, 6, 1'b0, 2);
    wait_done(1);

    // Saturation
    mem[20][0] = 70000; mem[20][1] = -70000; mem[20][2] = 32767; mem[20][3] = -32768;
    issue(1, 20, 7, 1'b0, 0);
    wait_done(1);
    issue(1, 20, 8, 1'b0, 31);
    wait_done(1);

    // Wrap-around on both address spaces
    issue(4, ROWS - 2, 254, 1'b0, 1);
    wait_done(4);

    // Zero rows
    issue(0, 3, 3, 1'b0, 0);
    wait_done(0);

    // Start while busy is ignored
    issue(6, 50, 60, 1'b1, 3);
    num_row = 16'd3; accum_base_addr = 8'd90; out_base_addr = 8'd91; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(6);

    // Reset mid-transfer
    issue(8, 30, 40, 1'b0, 0);
    repeat (2) @(negedge clk);
    #3 rstn = 1'b0;
    #1;
    check_outputs_zero("abort");
    exp_q.delete();
    rd_q.delete();
    base = done_cnt;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (15) @(negedge clk);
    check_eq("no_done_after_abort", done_cnt - base, 0);
    issue(8, 30, 40, 1'b0, 0);
    wait_done(8);

    // Randomised transfers
    for (int t = 0; t < 12; t++) begin
      int n, ab, ob, sh;
      n  = $urandom_range(1, 12);
      ab = $urandom_range(0, ROWS - 1);
      ob = $urandom_range(0, 255);
      sh = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 31) : $urandom_range(0, 8);
      for (int i = 0; i < n; i++)
        for (int c = 0; c < SC; c++) mem[(ab + i) % ROWS][c] = rand_val();
      issue(n, ab, ob, 1'($urandom), sh);
      wait_done(n);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
